// File: rtl/game_sprite_update_sequencer_if.sv
// Request/acknowledge link between the sprite update sequencer and the shared
// position-update engine.
interface game_sprite_update_sequencer_if #(
    parameter int unsigned SEL_W = 1
) ();
    logic             upd_req;
    logic [SEL_W-1:0] upd_sel;
    logic             upd_ack;

    modport master (output upd_req, output upd_sel, input upd_ack);
    modport slave  (input upd_req, input upd_sel, output upd_ack);
endinterface

// File: rtl/game_sprite_update_sequencer.sv
// Frame-rate scheduler: every FRAME_DIV-th frame, walks the enabled sprites in index order and
// grants the shared position-update engine to each one through a req/ack handshake.
module game_sprite_update_sequencer #(
    parameter int unsigned N_SPRITES = 2,
    parameter int unsigned SEL_W     = 1,
    parameter int unsigned FRAME_DIV = 1,
    parameter int unsigned DIV_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          frame_start,
    input  logic [N_SPRITES-1:0]          sprite_enable_update,
    game_sprite_update_sequencer_if.master upd,
    output logic                          busy,
    output logic                          pass_done,
    output logic                          frame_overrun
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StReq  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [N_SPRITES-1:0] pend_q, pend_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 ovr_q, ovr_d;
    logic [SEL_W-1:0]     low_idx;

    // Descending walk so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = int'(N_SPRITES) - 1; i >= 0; i--) begin
            if (pend_q[i]) low_idx = SEL_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        ovr_d   = frame_start && (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                        div_d   = '0;
                        pend_d  = sprite_enable_update;
                        state_d = StScan;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            StScan: begin
                if (pend_q == '0) begin
                    state_d = StDone;
                end else begin
                    sel_d   = low_idx;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (upd.upd_ack) begin
                    pend_d  = pend_q & ~(N_SPRITES'(1) << sel_q);
                    state_d = StScan;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            pend_q  <= '0;
            sel_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            ovr_q   <= ovr_d;
        end
    end

    assign upd.upd_req   = (state_q == StReq);
    assign upd.upd_sel   = sel_q;
    assign busy          = (state_q != StIdle);
    assign pass_done     = (state_q == StDone);
    assign frame_overrun = ovr_q;
endmodule

// File: tb/tb_game_sprite_update_sequencer.sv
// Randomized bench for game_sprite_update_sequencer: a 4-sprite instance for pass sequencing
// and a 2-sprite FRAME_DIV=3 instance for frame division.
module tb_game_sprite_update_sequencer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_start_div = 1'b0;
    logic [3:0] enable = '0;
    logic [1:0] enable_div = '0;
    logic       busy, pass_done, frame_overrun;
    logic       busy_div, pass_done_div, overrun_div;
    int         checks = 0;
    int         passed = 0;
    bit         stall = 1'b0;
    int         dly_q[$];
    int         wait_cnt = 0;

    game_sprite_update_sequencer_if #(.SEL_W(2)) bus ();
    game_sprite_update_sequencer_if #(.SEL_W(1)) bus_div ();

    game_sprite_update_sequencer #(
        .N_SPRITES(4), .SEL_W(2), .FRAME_DIV(1), .DIV_W(8)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .sprite_enable_update(enable), .upd(bus.master), .busy(busy),
        .pass_done(pass_done), .frame_overrun(frame_overrun)
    );

    game_sprite_update_sequencer #(
        .N_SPRITES(2), .SEL_W(1), .FRAME_DIV(3), .DIV_W(8)
    ) u_div (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start_div),
        .sprite_enable_update(enable_div), .upd(bus_div.master), .busy(busy_div),
        .pass_done(pass_done_div), .frame_overrun(overrun_div)
    );

    // The second engine acknowledges immediately.
    assign bus_div.upd_ack = bus_div.upd_req;

    always #5 clk = ~clk;

    // Advance one clock, then act as the engine for the new cycle (ack noise outside requests).
    task automatic step();
        @(posedge clk);
        #1;
        bus.upd_ack = 1'b0;
        if (bus.upd_req) begin
            if (!stall) begin
                int d;
                d = (dly_q.size() != 0) ? dly_q[0] : 0;
                if (wait_cnt >= d) begin
                    bus.upd_ack = 1'b1;
                    wait_cnt = 0;
                    if (dly_q.size() != 0) void'(dly_q.pop_front());
                end else begin
                    wait_cnt++;
                end
            end
        end else begin
            bus.upd_ack = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else passed++;
    endtask

    // Model: sprites served are the set bits of the mask at pass start, ascending; each costs
    // its ack delay + 2 cycles, and pass_done lands 2 cycles after the pass start otherwise.
    task automatic run_pass(input logic [3:0] mask, input logic [3:0] mid_mask,
                            input int min_dly, input int max_dly, input string name);
        int exp_code, got_code, exp_done, done_at, busy_cnt, sel_bad, prev_req, prev_sel;
        exp_code = 0; got_code = 0; exp_done = 2; done_at = -1; busy_cnt = 0; sel_bad = 0;
        prev_req = 0; prev_sel = 0;
        dly_q.delete();
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                int d;
                d = int'($urandom_range(max_dly, min_dly));
                dly_q.push_back(d);
                exp_code = exp_code * 5 + i + 1;
                exp_done += d + 2;
            end
        end
        wait_cnt = 0;
        enable = mask;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        enable = mid_mask;
        for (int k = 1; k <= 300 && done_at < 0; k++) begin
            if (busy) busy_cnt++;
            if (pass_done) done_at = k;
            if (bus.upd_req && prev_req != 0 && int'(bus.upd_sel) != prev_sel) sel_bad = 1;
            if (bus.upd_req && bus.upd_ack) got_code = got_code * 5 + int'(bus.upd_sel) + 1;
            prev_req = int'(bus.upd_req);
            prev_sel = int'(bus.upd_sel);
            if (done_at < 0) step();
        end
        chk({name, " pass_done cycle"}, done_at, exp_done);
        chk({name, " busy cycles"}, busy_cnt, exp_done);
        chk({name, " served sequence"}, got_code, exp_code);
        chk({name, " upd_sel stable"}, sel_bad, 0);
        step();
        chk({name, " idle after done"}, int'({busy, pass_done, bus.upd_req}), 0);
    endtask

    task automatic test_reset();
        #3;
        chk("reset outputs", int'({bus.upd_req, busy, pass_done, frame_overrun, bus.upd_sel}), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        stall = 1'b1;
        enable = 4'b0100;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (3) step();
        chk("req before reset", int'({bus.upd_req, bus.upd_sel}), 6);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset mid-req",
            int'({bus.upd_req, busy, pass_done, frame_overrun, bus.upd_sel}), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        stall = 1'b0;
        step();
        chk("first clock after release",
            int'({bus.upd_req, busy, pass_done, frame_overrun, bus.upd_sel}), 0);
        run_pass(4'($urandom_range(1, 15)), 4'($urandom), 0, 3, "fresh pass");
    endtask

    task automatic test_overrun();
        int ovr_cnt, done_seen, extra_busy;
        ovr_cnt = 0; done_seen = 0; extra_busy = 0;
        stall = 1'b1;
        dly_q.delete();
        wait_cnt = 0;
        enable = 4'b1000;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (3) step();
        for (int p = 0; p < 2; p++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            chk("overrun pulse", int'(frame_overrun), 1);
            step();
            chk("overrun one cycle", int'(frame_overrun), 0);
        end
        stall = 1'b0;
        for (int k = 0; k < 50 && done_seen == 0; k++) begin
            if (frame_overrun) ovr_cnt++;
            if (pass_done) done_seen = 1;
            else step();
        end
        chk("stalled pass finishes", done_seen, 1);
        for (int k = 0; k < 10; k++) begin
            step();
            if (busy || frame_overrun) extra_busy++;
        end
        chk("no extra pass or overrun", extra_busy + ovr_cnt, 0);
    endtask

    task automatic test_divider();
        int passes, ovr;
        ovr = 0;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        for (int p = 1; p <= 7; p++) begin
            passes = 0;
            enable_div = 2'($urandom);
            frame_start_div = 1'b1;
            step();
            frame_start_div = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (pass_done_div) passes++;
                if (overrun_div) ovr++;
                step();
            end
            chk($sformatf("divider pulse %0d passes", p), passes, (p % 3 == 0) ? 1 : 0);
        end
        chk("divider no overrun", ovr, 0);
    endtask

    initial begin
        bus.upd_ack = 1'b0;
        test_reset();
        run_pass(4'b0011, 4'b0011, 0, 0, "mask 0011");
        run_pass(4'b1010, 4'b0101, 5, 5, "snapshot 1010");
        run_pass(4'b0000, 4'b1111, 0, 0, "empty mask");
        for (int r = 0; r < 6; r++) begin
            run_pass(4'($urandom), 4'($urandom), 0, 4, $sformatf("random %0d", r));
        end
        test_overrun();
        test_divider();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
